// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store, one access in flight.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants when both requesters are valid (default: DM over IF).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              dm_req_valid,
  input  logic              dm_req_write,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_resp_valid,
  output logic [DATA_W-1:0] dm_resp_data,
  output logic              mem_req_valid,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              owner,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_next;
  logic grant, grant_dm, resp_hit;
  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_dm = (dm_req_valid && if_req_valid) ? !owner : dm_req_valid;
`else
    grant_dm = dm_req_valid;
`endif
    grant = state == IDLE && (if_req_valid || dm_req_valid);
    resp_hit = state == WAIT && mem_resp_valid;
    state_next = grant ? REQ : (state == REQ && mem_req_ready) ? WAIT : resp_hit ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  // ready is gated by rst_n so every output reads 0 while reset is held
  assign if_req_ready  = rst_n && grant && !grant_dm;
  assign dm_req_ready  = rst_n && grant && grant_dm;
  assign mem_req_valid = state == REQ;
  assign busy          = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner         <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      if_resp_valid <= 1'b0;
      dm_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      dm_resp_data  <= '0;
    end else begin
      if (grant) begin
        owner         <= grant_dm;
        mem_req_write <= grant_dm && dm_req_write;
        mem_req_addr  <= grant_dm ? dm_req_addr : if_req_addr;
        mem_req_wdata <= grant_dm ? dm_req_wdata : '0;
      end
      if_resp_valid <= resp_hit && !owner;
      dm_resp_valid <= resp_hit && owner;
      if (resp_hit && !owner) if_resp_data <= mem_req_write ? '0 : mem_resp_data;
      if (resp_hit && owner) dm_resp_data <= mem_req_write ? '0 : mem_resp_data;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req_valid = 1'b0, dm_req_valid = 1'b0, dm_req_write = 1'b0;
  logic [31:0] if_req_addr = '0, dm_req_addr = '0, dm_req_wdata = '0;
  logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        if_req_ready, if_resp_valid, dm_req_ready, dm_resp_valid;
  logic [31:0] if_resp_data, dm_resp_data, mem_req_addr, mem_req_wdata;
  logic        mem_req_valid, mem_req_write, owner, busy;
  int vectors = 0, miscompares = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic first_dm = 1'b0;
`else
  logic first_dm = 1'b1;
`endif

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .dm_req_valid(dm_req_valid), .dm_req_write(dm_req_write), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
    .dm_resp_valid(dm_resp_valid), .dm_resp_data(dm_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    if_req_valid = 1'b1;
    #1;
    chk("rst_if_ready", if_req_ready, 0);
    chk("rst_outputs", {mem_req_valid, mem_req_write, owner, busy, if_resp_valid, dm_resp_valid}, 0);
    chk("rst_fields", {mem_req_addr, mem_req_wdata}, 0);
    if_req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    // single fetch
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0040;
    #1;
    chk("f_ready", {if_req_ready, dm_req_ready, busy}, 3'b100);
    step();
    if_req_valid = 1'b0;
    chk("f_req", {mem_req_valid, mem_req_write, busy}, 3'b101);
    chk("f_addr", mem_req_addr, 32'h40);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    chk("f_req_drop", mem_req_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0050_0093;
    step();
    mem_resp_valid = 1'b0;
    chk("f_resp", {if_resp_valid, dm_resp_valid, busy, owner}, 4'b1000);
    chk("f_data", if_resp_data, 32'h0050_0093);
    step();
    chk("f_pulse_end", {if_resp_valid, if_resp_data}, {1'b0, 32'h0050_0093});
    // store with three stalled REQ cycles
    dm_req_valid = 1'b1;
    dm_req_write = 1'b1;
    dm_req_addr  = 32'h100;
    dm_req_wdata = 32'hDEAD_BEEF;
    #1;
    chk("s_ready", {dm_req_ready, if_req_ready}, 2'b10);
    step();
    dm_req_valid = 1'b0;
    dm_req_addr  = 32'h999;
    dm_req_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("s_hold", {mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata}, {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF});
      if (i == 3) mem_req_ready = 1'b1;
      step();
    end
    mem_req_ready  = 1'b0;
    chk("s_wait", {mem_req_valid, busy}, 2'b01);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h5555_5555;
    step();
    mem_resp_valid = 1'b0;
    chk("s_ack", {dm_resp_valid, if_resp_valid, owner}, 3'b101);
    chk("s_ack_data", dm_resp_data, 0);
    step();
    chk("s_ack_end", dm_resp_valid, 0);
    // simultaneous requests, owner is 1 here
    if_req_valid = 1'b1;
    if_req_addr  = 32'h44;
    dm_req_valid = 1'b1;
    dm_req_write = 1'b0;
    dm_req_addr  = 32'h200;
    #1;
    chk("b_first", {dm_req_ready, if_req_ready}, {first_dm, !first_dm});
    step();
    if (first_dm) dm_req_valid = 1'b0;
    else if_req_valid = 1'b0;
    chk("b_first_addr", mem_req_addr, first_dm ? 32'h200 : 32'h44);
    chk("b_no_ready_req", {dm_req_ready, if_req_ready}, 2'b00);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hAAAA_0001;
    step();
    mem_resp_valid = 1'b0;
    chk("b_first_resp", {dm_resp_valid, if_resp_valid}, {first_dm, !first_dm});
    chk("b_first_data", first_dm ? dm_resp_data : if_resp_data, 32'hAAAA_0001);
    chk("b_second", {dm_req_ready, if_req_ready}, {!first_dm, first_dm});
    step();
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    chk("b_second_addr", mem_req_addr, first_dm ? 32'h44 : 32'h200);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBBBB_0002;
    step();
    mem_resp_valid = 1'b0;
    chk("b_second_resp", {dm_resp_valid, if_resp_valid}, {!first_dm, first_dm});
    chk("b_second_data", first_dm ? if_resp_data : dm_resp_data, 32'hBBBB_0002);
    step();
    // spurious response and ready in IDLE
    mem_resp_valid = 1'b1;
    mem_req_ready  = 1'b1;
    mem_resp_data  = 32'h1234;
    step();
    chk("sp_idle", {busy, mem_req_valid}, 2'b00);
    step();
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    chk("sp_no_pulse", {if_resp_valid, dm_resp_valid, busy}, 3'b000);
    step();
    chk("sp_no_pulse2", {if_resp_valid, dm_resp_valid}, 2'b00);
    // reset while waiting for a fetch response
    if_req_valid = 1'b1;
    if_req_addr  = 32'h80;
    step();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("r_wait", {busy, mem_req_valid}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("r_async", {busy, mem_req_valid, owner, mem_req_write, if_resp_valid, dm_resp_valid}, 0);
    chk("r_fields", {mem_req_addr, if_resp_data}, 0);
    step();
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hAAAA;
    step();
    mem_resp_valid = 1'b0;
    chk("r_no_resp", {if_resp_valid, dm_resp_valid, busy}, 3'b000);
    step();
    chk("r_no_resp2", {if_resp_valid, dm_resp_valid, if_resp_data}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
